// File: rtl/md_defs.sv
// Shared multiply/divide definitions: MDOp encodings, default latencies, latched request.
package md_defs;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  function automatic logic is_launch_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction
endpackage

// File: rtl/md_core.sv
// Combinational datapath: 64-bit {HI,LO} result and divide-by-zero flag from latched operands.
module md_core
  import md_defs::*;
(
  input  md_req_t     req,
  output logic [63:0] res,
  output logic        div_zero
);
  logic [31:0] dvs;

  always_comb begin
    res      = '0;
    div_zero = (req.b == 32'd0) && ((req.op == MD_DIV) || (req.op == MD_DIVU));
    // substitute divisor keeps the divider defined; the result is discarded on div-by-zero
    dvs      = (req.b == 32'd0) ? 32'd1 : req.b;
    case (req.op)
      MD_MULT:  res = $signed({{32{req.a[31]}}, req.a}) * $signed({{32{req.b[31]}}, req.b});
      MD_MULTU: res = {32'd0, req.a} * {32'd0, req.b};
      MD_DIV: begin
        if (req.a == 32'h8000_0000 && req.b == 32'hFFFF_FFFF)
          res = {32'h0000_0000, 32'h8000_0000};
        else
          res = {32'($signed(req.a) % $signed(dvs)), 32'($signed(req.a) / $signed(dvs))};
      end
      MD_DIVU:  res = {req.a % dvs, req.a / dvs};
      default:  res = '0;
    endcase
  end
endmodule

// File: rtl/mult_div.sv
// Multi-cycle MULT/DIV unit owning HI/LO; fixed-latency busy countdown, MTHI/MTLO when idle.
module mult_div
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  md_op_e      op;
  md_req_t     req;
  logic [CW-1:0] cnt;
  logic [63:0] res;
  logic        div_zero;
  logic        launch, done, mt_ok;

  assign op     = md_op_e'(MDOp);
  assign launch = Start && !Busy && is_launch_op(op);
  assign done   = Busy && (cnt == CW'(1));
  // an MT on the completion edge still lands, overriding only its own register
  assign mt_ok  = !Busy || done;

  md_core u_core (
    .req      (req),
    .res      (res),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req  <= '{op: MD_NONE, a: 32'd0, b: 32'd0};
      cnt  <= '0;
      Busy <= 1'b0;
      HI   <= 32'd0;
      LO   <= 32'd0;
    end else begin
      if (launch) begin
        req  <= '{op: op, a: SrcA_E, b: SrcB_E};
        cnt  <= is_mult_op(op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        Busy <= 1'b1;
      end else if (Busy) begin
        cnt <= cnt - CW'(1);
        if (done) Busy <= 1'b0;
      end
      if (done && !div_zero) begin
        HI <= res[63:32];
        LO <= res[31:0];
      end
      if (mt_ok && op == MD_MTHI) HI <= SrcA_E;
      if (mt_ok && op == MD_MTLO) LO <= SrcA_E;
    end
  end
endmodule

// File: tb/tb_mult_div.sv
// Directed self-checking bench for mult_div with hand-computed HI/LO/Busy expectations.
module tb_mult_div;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] SrcA_E = 32'd0;
  logic [31:0] SrcB_E = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;

  int nvec = 0;
  int nerr = 0;

  mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // launch edge, then n busy cycles with operands scrambled, ending just after completion edge
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string tag);
    Start = 1'b1; MDOp = op; SrcA_E = a; SrcB_E = b;
    step();
    Start = 1'b0; MDOp = 3'd0; SrcA_E = 32'hDEAD_BEEF; SrcB_E = 32'h0BAD_F00D;
    for (int c = 1; c <= n; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), {31'd0, Busy}, 32'd1);
      step();
    end
    chk({tag, " busy done"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    step();
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset hi", HI, 32'd0);
    chk("reset lo", LO, 32'd0);
    step();
    reset = 1'b0;
    step();

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5, "mult");
    chk("mult hi", HI, 32'hFFFF_FFFF);
    chk("mult lo", LO, 32'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "multu");
    chk("multu hi", HI, 32'hFFFF_FFFE);
    chk("multu lo", LO, 32'h0000_0001);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, "div");
    chk("div hi", HI, 32'hFFFF_FFFF);
    chk("div lo", LO, 32'hFFFF_FFFD);

    run_op(3'd4, 32'd7, 32'd0, 10, "divu0");
    chk("divu0 hi", HI, 32'hFFFF_FFFF);
    chk("divu0 lo", LO, 32'hFFFF_FFFD);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, "divovf");
    chk("divovf hi", HI, 32'd0);
    chk("divovf lo", LO, 32'h8000_0000);

    run_op(3'd4, 32'd100, 32'd7, 10, "divu");
    chk("divu hi", HI, 32'd2);
    chk("divu lo", LO, 32'd14);

    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 10, "divneg");
    chk("divneg hi", HI, 32'd1);
    chk("divneg lo", LO, 32'hFFFF_FFFD);

    // DIV 100 / -7 with a MULT attempt at cycle 1 and MTHI at cycle 3
    Start = 1'b1; MDOp = 3'd3; SrcA_E = 32'd100; SrcB_E = 32'hFFFF_FFF9;
    step();
    Start = 1'b0; MDOp = 3'd0;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("ign busy c%0d", c), {31'd0, Busy}, 32'd1);
      case (c)
        1: begin Start = 1'b1; MDOp = 3'd1; SrcA_E = 32'd5; SrcB_E = 32'd5; end
        3: begin Start = 1'b0; MDOp = 3'd5; SrcA_E = 32'h1234; end
        default: begin Start = 1'b0; MDOp = 3'd0; SrcA_E = 32'h5A5A_5A5A; end
      endcase
      step();
      if (c == 3) chk("ign mthi hi", HI, 32'd1);
    end
    chk("ign busy done", {31'd0, Busy}, 32'd0);
    chk("ign hi", HI, 32'd2);
    chk("ign lo", LO, 32'hFFFF_FFF2);
    step();
    chk("ign no mult", {31'd0, Busy}, 32'd0);

    // MTLO on the completion edge of MULT 2*3
    Start = 1'b1; MDOp = 3'd1; SrcA_E = 32'd2; SrcB_E = 32'd3;
    step();
    Start = 1'b0; MDOp = 3'd0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin MDOp = 3'd6; SrcA_E = 32'h0000_AAAA; end
      step();
    end
    MDOp = 3'd0;
    chk("mtlo busy", {31'd0, Busy}, 32'd0);
    chk("mtlo lo", LO, 32'h0000_AAAA);
    chk("mtlo hi", HI, 32'd0);

    // idle MTHI, with Start high to show it is ignored for MT
    Start = 1'b1; MDOp = 3'd5; SrcA_E = 32'h0000_5555;
    step();
    Start = 1'b0; MDOp = 3'd0;
    chk("mthi hi", HI, 32'h0000_5555);
    chk("mthi lo", LO, 32'h0000_AAAA);
    chk("mthi busy", {31'd0, Busy}, 32'd0);

    // reset at cycle 4 of a DIV
    Start = 1'b1; MDOp = 3'd3; SrcA_E = 32'd100; SrcB_E = 32'd7;
    step();
    Start = 1'b0; MDOp = 3'd0;
    for (int c = 1; c < 4; c++) step();
    reset = 1'b1;
    #1;
    chk("rst busy", {31'd0, Busy}, 32'd0);
    chk("rst hi", HI, 32'd0);
    chk("rst lo", LO, 32'd0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) step();
    chk("rst later busy", {31'd0, Busy}, 32'd0);
    chk("rst later hi", HI, 32'd0);
    chk("rst later lo", LO, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
